// File: rtl/mem_bus_responder_pkg.sv
// Shared definitions for the memory-bus responder: FSM states, region codes,
// I/O register offsets and the default address map used by datapath and RegisterFile.
package mem_bus_responder_pkg;

    localparam int          BUS_WIDTH             = 16;
    localparam logic [15:0] INSTRUCTION_MEM_DEF   = 16'h0000;
    localparam logic [15:0] INTERRUPT_CONTROL_DEF = 16'h5FFF;
    localparam logic [15:0] DATA_STACK_DEF        = 16'h6FFE;
    localparam logic [15:0] IO_MEM_DEF            = 16'hCFFD;

    localparam int IO_OUT_OFS    = 0;
    localparam int IO_IN_OFS     = 1;
    localparam int IO_STATUS_OFS = 2;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        RGN_RAM,
        RGN_REG,
        RGN_IO,
        RGN_UNMAPPED
    } region_t;

endpackage

// File: rtl/mem_bus_responder_if.sv
// Request/acknowledge memory bus between the multicycle control unit (master)
// and the responder (slave): req/we/addr/wdata in, rdata/ack/err back.
interface mem_bus_responder_if #(
    parameter int WIDTH = 16
);
    logic             req;
    logic             we;
    logic [WIDTH-1:0] addr;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] rdata;
    logic             ack;
    logic             err;

    modport master (
        output req, we, addr, wdata,
        input  rdata, ack, err
    );

    modport slave (
        input  req, we, addr, wdata,
        output rdata, ack, err
    );
endinterface

// File: rtl/mem_bus_responder_sync2.sv
// Two-flop synchroniser for a WIDTH-bit asynchronous input bus.
// Ports: clk, reset (async active-low), d (async in), q (synchronised out).
module mem_bus_responder_sync2 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/mem_bus_responder.sv
// Memory-bus target: decodes RAM / interrupt-mask / I/O / unmapped regions,
// drives a sync RAM, and answers each req with one ack (+err) pulse.
// Ports: clk, reset (async active-low), bus (slave modport), ram_* RAM port,
// int_mask, io_out, io_in.
module mem_bus_responder
    import mem_bus_responder_pkg::*;
#(
    parameter int               WIDTH             = BUS_WIDTH,
    parameter logic [WIDTH-1:0] INTERRUPT_CONTROL = INTERRUPT_CONTROL_DEF,
    parameter logic [WIDTH-1:0] IO_MEM            = IO_MEM_DEF,
    parameter int               WAIT_STATES       = 0,
    parameter bit               WRITE_PROTECT     = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    mem_bus_responder_if.slave   bus,
    output logic                 ram_en,
    output logic                 ram_we,
    output logic [WIDTH-1:0]     ram_addr,
    output logic [WIDTH-1:0]     ram_wdata,
    input  logic [WIDTH-1:0]     ram_rdata,
    output logic [7:0]           int_mask,
    output logic [WIDTH-1:0]     io_out,
    input  logic [WIDTH-1:0]     io_in
);
    localparam logic [WIDTH-1:0] IO_OUT_ADDR  = IO_MEM + WIDTH'(IO_OUT_OFS);
    localparam logic [WIDTH-1:0] IO_IN_ADDR   = IO_MEM + WIDTH'(IO_IN_OFS);
    localparam logic [WIDTH-1:0] IO_STAT_ADDR = IO_MEM + WIDTH'(IO_STATUS_OFS);

    state_t           state;
    region_t          region;
    region_t          reqRegion;
    logic             weQ;
    logic             protQ;
    logic [WIDTH-1:0] addrQ;
    logic [WIDTH-1:0] wdataQ;
    logic [WIDTH-1:0] holdData;
    logic [WIDTH-1:0] ioInSync;
    logic [3:0]       waitCnt;
    logic             reqProt;

    function automatic region_t decode(input logic [WIDTH-1:0] a);
        if (a == INTERRUPT_CONTROL)
            return RGN_REG;
        else if (a >= IO_MEM && a <= IO_STAT_ADDR)
            return RGN_IO;
        else if (a > IO_STAT_ADDR)
            return RGN_UNMAPPED;
        else
            return RGN_RAM;
    endfunction

    assign reqRegion = decode(bus.addr);
    // Only RAM writes into the instruction region are blocked.
    assign reqProt = WRITE_PROTECT && bus.we
                   && (reqRegion == RGN_RAM)
                   && (bus.addr < INTERRUPT_CONTROL);

    mem_bus_responder_sync2 #(.WIDTH(WIDTH)) ioSync (
        .clk   (clk),
        .reset (reset),
        .d     (io_in),
        .q     (ioInSync)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            region    <= RGN_RAM;
            weQ       <= 1'b0;
            protQ     <= 1'b0;
            addrQ     <= '0;
            wdataQ    <= '0;
            holdData  <= '0;
            waitCnt   <= '0;
            bus.rdata <= '0;
            bus.ack   <= 1'b0;
            bus.err   <= 1'b0;
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            int_mask  <= '0;
            io_out    <= '0;
        end else begin
            ram_en  <= 1'b0;
            ram_we  <= 1'b0;
            bus.ack <= 1'b0;
            bus.err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.req) begin
                        addrQ  <= bus.addr;
                        weQ    <= bus.we;
                        wdataQ <= bus.wdata;
                        region <= reqRegion;
                        protQ  <= reqProt;
                        state  <= ACCESS;
                        // Strobe is registered so it is high during ACCESS.
                        if (reqRegion == RGN_RAM) begin
                            ram_en    <= 1'b1;
                            ram_we    <= bus.we && !reqProt;
                            ram_addr  <= bus.addr;
                            ram_wdata <= bus.wdata;
                        end
                    end
                end
                ACCESS: begin
                    state <= DONE;
                    unique case (region)
                        RGN_RAM: begin
                            holdData <= wdataQ;
                            waitCnt  <= '0;
                            if (WAIT_STATES > 0)
                                state <= WAIT;
                        end
                        RGN_REG: begin
                            if (weQ) begin
                                int_mask <= wdataQ[7:0];
                                holdData <= wdataQ;
                            end else begin
                                holdData <= WIDTH'(int_mask);
                            end
                        end
                        RGN_IO: begin
                            if (addrQ == IO_OUT_ADDR) begin
                                if (weQ) io_out <= wdataQ;
                                holdData <= weQ ? wdataQ : io_out;
                            end else if (addrQ == IO_IN_ADDR) begin
                                holdData <= ioInSync;
                            end else begin
                                holdData <= WIDTH'(io_out != '0);
                            end
                        end
                        RGN_UNMAPPED: begin
                            holdData <= '0;
                        end
                    endcase
                end
                WAIT: begin
                    if (waitCnt == 4'(WAIT_STATES - 1))
                        state <= DONE;
                    else
                        waitCnt <= waitCnt + 4'd1;
                end
                DONE: begin
                    bus.ack   <= 1'b1;
                    bus.err   <= (region == RGN_UNMAPPED) || protQ;
                    bus.rdata <= (region == RGN_RAM && !weQ)
                               ? ram_rdata : holdData;
                    state     <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed bench for mem_bus_responder (WAIT_STATES=3) with a behavioural
// sync RAM; expected values are hand-computed constants.
module tb_mem_bus_responder;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ram_en;
    logic        ram_we;
    logic [15:0] ram_addr;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata = '0;
    logic [7:0]  int_mask;
    logic [15:0] io_out;
    logic [15:0] io_in = '0;
    logic [15:0] mem [0:255];

    int nChecks = 0;
    int nPass   = 0;

    mem_bus_responder_if #(.WIDTH(16)) bus ();

    mem_bus_responder #(
        .WIDTH         (16),
        .WAIT_STATES   (3),
        .WRITE_PROTECT (1'b1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .int_mask  (int_mask),
        .io_out    (io_out),
        .io_in     (io_in)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr[7:0]] <= ram_wdata;
            ram_rdata <= mem[ram_addr[7:0]];
        end
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        nChecks++;
        if (got === exp)
            nPass++;
        else
            $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic doAccess(input  logic        w,
                            input  logic [15:0] a,
                            input  logic [15:0] d,
                            input  logic        keepReq,
                            output int          lat,
                            output logic [15:0] rd,
                            output logic        e,
                            output logic        sawEn,
                            output logic        sawWe);
        @(negedge clk);
        bus.req   = 1'b1;
        bus.we    = w;
        bus.addr  = a;
        bus.wdata = d;
        @(posedge clk);
        lat   = 99;
        rd    = '0;
        e     = 1'b0;
        sawEn = 1'b0;
        sawWe = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            #1;
            if (ram_en) sawEn = 1'b1;
            if (ram_en && ram_we) sawWe = 1'b1;
            @(posedge clk);
            #1;
            if (bus.ack) begin
                lat = i;
                rd  = bus.rdata;
                e   = bus.err;
                break;
            end
        end
        if (!keepReq) bus.req = 1'b0;
    endtask

    int          lat;
    logic [15:0] rd;
    logic        e;
    logic        sEn;
    logic        sWe;
    logic        ackSeen;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[8'h10] = 16'h1111;
        bus.req   = 1'b0;
        bus.we    = 1'b0;
        bus.addr  = '0;
        bus.wdata = '0;
        io_in     = 16'h3C3C;

        #1;
        check("rst_ack",     {31'b0, bus.ack}, 32'd0);
        check("rst_err",     {31'b0, bus.err}, 32'd0);
        check("rst_ram_en",  {31'b0, ram_en},  32'd0);
        check("rst_rdata",   {16'b0, bus.rdata}, 32'd0);
        check("rst_int_mask",{24'b0, int_mask}, 32'd0);
        check("rst_io_out",  {16'b0, io_out},  32'd0);

        // Reset asserted while the access sits in WAIT.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        bus.req  = 1'b1;
        bus.we   = 1'b0;
        bus.addr = 16'h6000;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset   = 1'b0;
        bus.req = 1'b0;
        #1;
        check("midwait_ram_en", {31'b0, ram_en}, 32'd0);
        ackSeen = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (bus.ack) ackSeen = 1'b1;
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (bus.ack) ackSeen = 1'b1;
        end
        check("midwait_no_ack",   {31'b0, ackSeen}, 32'd0);
        check("midwait_int_mask", {24'b0, int_mask}, 32'd0);

        // RAM write / read with 3 wait states.
        doAccess(1'b1, 16'h6000, 16'hBEEF, 1'b0, lat, rd, e, sEn, sWe);
        check("wr6000_lat", lat, 32'd5);
        check("wr6000_err", {31'b0, e}, 32'd0);
        check("wr6000_we",  {31'b0, sWe}, 32'd1);
        check("wr6000_mem", {16'b0, mem[8'h00]}, 32'h0000BEEF);
        doAccess(1'b0, 16'h6000, 16'h0000, 1'b0, lat, rd, e, sEn, sWe);
        check("rd6000_lat",   lat, 32'd5);
        check("rd6000_rdata", {16'b0, rd}, 32'h0000BEEF);

        // Protected write into instruction region.
        doAccess(1'b1, 16'h0010, 16'h1234, 1'b0, lat, rd, e, sEn, sWe);
        check("prot_ram_en", {31'b0, sEn}, 32'd1);
        check("prot_ram_we", {31'b0, sWe}, 32'd0);
        check("prot_err",    {31'b0, e},   32'd1);
        check("prot_lat",    lat, 32'd5);
        doAccess(1'b0, 16'h0010, 16'h0000, 1'b0, lat, rd, e, sEn, sWe);
        check("prot_rd_rdata", {16'b0, rd}, 32'h00001111);
        check("prot_rd_err",   {31'b0, e},  32'd0);

        // Interrupt-mask register.
        doAccess(1'b1, 16'h5FFF, 16'h00A5, 1'b0, lat, rd, e, sEn, sWe);
        check("reg_wr_lat",   lat, 32'd2);
        check("reg_wr_err",   {31'b0, e}, 32'd0);
        check("reg_int_mask", {24'b0, int_mask}, 32'h000000A5);
        doAccess(1'b0, 16'h5FFF, 16'h0000, 1'b0, lat, rd, e, sEn, sWe);
        check("reg_rd_rdata", {16'b0, rd}, 32'h000000A5);
        check("reg_rd_err",   {31'b0, e}, 32'd0);

        // Memory-mapped I/O.
        doAccess(1'b0, 16'hCFFE, 16'h0000, 1'b0, lat, rd, e, sEn, sWe);
        check("io_in_rdata", {16'b0, rd}, 32'h00003C3C);
        check("io_in_err",   {31'b0, e}, 32'd0);
        doAccess(1'b0, 16'hCFFF, 16'h0000, 1'b0, lat, rd, e, sEn, sWe);
        check("status0", {16'b0, rd}, 32'd0);
        doAccess(1'b1, 16'hCFFD, 16'h0001, 1'b0, lat, rd, e, sEn, sWe);
        check("io_out", {16'b0, io_out}, 32'd1);
        doAccess(1'b0, 16'hCFFF, 16'h0000, 1'b0, lat, rd, e, sEn, sWe);
        check("status1", {16'b0, rd}, 32'd1);

        // Unmapped read, req held high for a back-to-back access.
        doAccess(1'b0, 16'hD000, 16'h0000, 1'b1, lat, rd, e, sEn, sWe);
        check("unmap_rdata", {16'b0, rd}, 32'd0);
        check("unmap_err",   {31'b0, e}, 32'd1);
        check("unmap_lat",   lat, 32'd2);
        @(posedge clk);
        #1;
        check("ack_pulse", {31'b0, bus.ack}, 32'd0);
        lat = 99;
        for (int i = 2; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (bus.ack) begin
                lat = i;
                e   = bus.err;
                break;
            end
        end
        bus.req = 1'b0;
        check("b2b_gap", lat, 32'd3);
        check("b2b_err", {31'b0, e}, 32'd1);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule
